intersection_phase_scheduler: RTL and testbench
===============================================

Name: intersection_phase_scheduler

Overview:
Sequences the two-road intersection (road A, road B) through its green, yellow and all-red phases using per-phase second counts.
- Extends green on vehicle demand, honours a police override request/acknowledge handshake, and supports a flashing-yellow mode.
- Drives both lamp heads and the two-digit BCD countdown display directly.
- Sits between the 1 Hz tick generator and the lamp/display drivers.

Parameters:
GREEN_MIN, 10, minimum green length in ticks (1..99)
GREEN_MAX, 30, maximum total green length including extensions (GREEN_MIN..99)
EXT_STEP, 5, ticks added per green extension (1..99)
YELLOW_T, 3, yellow length in ticks (1..99)
ALLRED_T, 1, all-red clearance length in ticks (1..99)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
tick  in  1  one-cycle strobe, one per second
a_tr  in  1  vehicle present on road A (level)
b_tr  in  1  vehicle present on road B (level)
ovr_req  in  1  police override request (level)
ovr_road  in  1  override target road: 0 = A green, 1 = B green
ovr_ack  out  1  override granted; requested road is green and held
flash_en  in  1  flashing-yellow mode request (level)
a_light  out  2  road A lamp: 00 red, 01 yellow, 10 green, 11 off
b_light  out  2  road B lamp, same encoding
ti_l  out  4  BCD units digit of remaining ticks in the current phase
ti_h  out  4  BCD tens digit of remaining ticks
phase  out  3  state code: 0 A_GRN, 1 A_YEL, 2 AR1, 3 B_GRN, 4 B_YEL, 5 AR2, 6 FLASH

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state AR2, rem = ALLRED_T, elapsed-green counter = 0.
  - Both lights 00, ovr_ack = 0, flash phase = lit.
  - {ti_h, ti_l} = BCD(ALLRED_T).
  - Reset wins over every other input and aborts any phase mid-count.
- Normal cycle: A_GRN -> A_YEL -> AR1 -> B_GRN -> B_YEL -> AR2 -> A_GRN.
  - Phase load values: greens GREEN_MIN, yellows YELLOW_T, all-reds ALLRED_T.
- Countdown, on each cycle with tick = 1:
  - If rem > 1: rem decrements.
  - Else the phase ends: the next state and its load value are registered on that same edge.
  - A phase therefore lasts exactly its load value in ticks.
  - Without tick, rem holds.
- Lamp outputs are registered and change on the same edge as the state.
- Green extension, evaluated at the end of a green phase:
  - A_GRN extends when a_tr = 1, b_tr = 0 and elapsed < GREEN_MAX. Then rem = min(EXT_STEP, GREEN_MAX - elapsed) and the state stays A_GRN.
  - B_GRN follows the same rule with the roles of a_tr and b_tr swapped.
  - elapsed counts ticks spent in the current green and clears on leaving green.
- Display: {ti_h, ti_l} = BCD of rem, updated on the same edge as rem. During a held override or FLASH it shows 0,0.
- Priority per cycle: rst > ovr_req > flash_en > countdown.
- Override:
  - While ovr_req = 1 the scheduler drives toward green on road ovr_road.
  - If the target is already green: the state holds, ovr_ack = 1 on the next edge, and the countdown is frozen.
  - If the other road is green: go immediately to that road's yellow (rem = YELLOW_T), then its all-red, then the target green. Yellow and all-red still run their full lengths.
  - If in a yellow or all-red: continue the normal sequence. If that sequence lands on the non-target green, apply the previous rule immediately.
  - From FLASH: go to AR2 if the target is A, or AR1 if the target is B, then to the target green.
  - ovr_ack = 1 only while the target road is green and ovr_req = 1.
  - If ovr_road changes while acked: ovr_ack drops on the next edge and the new target is sequenced.
  - On ovr_req falling: ovr_ack = 0 on the next edge. The current green restarts with rem = GREEN_MIN and elapsed = 0, and normal sequencing resumes.
- Flash:
  - With flash_en = 1 and ovr_req = 0, enter FLASH on the next edge from any state.
  - In FLASH, both lights are 01 and toggle between 01 and 11 on every tick; the first FLASH cycle is lit.
  - When flash_en falls, go to AR2 with rem = ALLRED_T, then A_GRN.
- Simultaneous events:
  - A tick in the same cycle as an override or flash entry is consumed by the entry; no extra decrement.
  - a_tr and b_tr both 1 means no extension.
- Safety invariant: a_light and b_light are never both non-red outside FLASH.

Test Plan:
- Reset, tick every 4 clks, sensors low: phase sequence 5,0,1,2,3,4,5. A_GRN lasts 10 ticks, A_YEL 3, AR 1. Display at A_GRN entry is ti_h=1, ti_l=0, then 0/9 ... 0/1.
- a_tr = 1, b_tr = 0 throughout: A_GRN totals exactly 30 ticks (10+5+5+5+5), then A_YEL. B_GRN stays 10 ticks.
- In A_GRN with rem = 7, raise ovr_req with ovr_road = 1: A_YEL on the next edge, then 3 ticks, AR1 for 1 tick, B_GRN with ovr_ack = 1 and display 0,0. Green holds for 50 ticks. On ovr_req falling, ovr_ack = 0 and B_GRN runs 10 ticks.
- flash_en = 1 mid-B_YEL: phase = 6 next edge, lights 01/01, toggling to 11/11 each tick. On flash_en falling: AR2 for 1 tick, then A_GRN.
- flash_en and ovr_req (road A) both asserted: the override wins and reaches A_GRN with ovr_ack = 1. Dropping ovr_req while flash_en stays high enters FLASH next edge.
- rst = 0 for one cycle mid-A_GRN with tick coincident: state AR2, display 0/1, lights 00/00, ovr_ack = 0.

Source files
------------

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase scheduler.
// Walks A_GRN -> A_YEL -> AR1 -> B_GRN -> B_YEL -> AR2 on a 1 Hz tick. It extends a green
// while only that road has demand, and serves a police override with a req/ack handshake.
// It also has a flashing-yellow mode and drives a two-digit BCD countdown.
// Ports:
//   clk, rst (sync, active-low)   clock and reset
//   tick                          one-cycle strobe per second
//   a_tr, b_tr                    vehicle presence on road A / B
//   ovr_req, ovr_road, ovr_ack    override request, target road (0 = A), grant
//   flash_en                      flashing-yellow request
//   a_light, b_light              lamp codes: 00 red, 01 yellow, 10 green, 11 off
//   ti_h, ti_l                    BCD tens / units of remaining ticks
//   phase                         current state code (0..6)
module intersection_phase_scheduler #(
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned GREEN_MAX = 30,
  parameter int unsigned EXT_STEP  = 5,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       a_tr,
  input  logic       b_tr,
  input  logic       ovr_req,
  input  logic       ovr_road,
  output logic       ovr_ack,
  input  logic       flash_en,
  output logic [1:0] a_light,
  output logic [1:0] b_light,
  output logic [3:0] ti_l,
  output logic [3:0] ti_h,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    StAGrn  = 3'd0,
    StAYel  = 3'd1,
    StAr1   = 3'd2,
    StBGrn  = 3'd3,
    StBYel  = 3'd4,
    StAr2   = 3'd5,
    StFlash = 3'd6
  } state_e;

  localparam logic [6:0] GreenMin = 7'(GREEN_MIN);
  localparam logic [6:0] GreenMax = 7'(GREEN_MAX);
  localparam logic [6:0] ExtStep  = 7'(EXT_STEP);
  localparam logic [6:0] YellowT  = 7'(YELLOW_T);
  localparam logic [6:0] AllredT  = 7'(ALLRED_T);

  localparam logic [1:0] LampRed = 2'b00;
  localparam logic [1:0] LampYel = 2'b01;
  localparam logic [1:0] LampGrn = 2'b10;
  localparam logic [1:0] LampOff = 2'b11;

  state_e     state_q, state_d;
  logic [6:0] rem_q, rem_d;
  logic [6:0] elapsed_q, elapsed_d;
  logic       ack_q, ack_d;
  logic       lit_q, lit_d;
  logic [1:0] a_light_q, a_light_d;
  logic [1:0] b_light_q, b_light_d;

  state_e     target, other, seq_next;
  logic       is_green, want_ext, do_count;
  logic [6:0] elapsed_inc, headroom, ext_rem;

  function automatic logic [6:0] load_of(state_e s);
    case (s)
      StAGrn, StBGrn: load_of = GreenMin;
      StAYel, StBYel: load_of = YellowT;
      default:        load_of = AllredT;
    endcase
  endfunction

  always_comb begin
    case (state_q)
      StAGrn:  seq_next = StAYel;
      StAYel:  seq_next = StAr1;
      StAr1:   seq_next = StBGrn;
      StBGrn:  seq_next = StBYel;
      StBYel:  seq_next = StAr2;
      default: seq_next = StAGrn;
    endcase
  end

  assign target      = ovr_road ? StBGrn : StAGrn;
  assign other       = ovr_road ? StAGrn : StBGrn;
  assign is_green    = (state_q == StAGrn) || (state_q == StBGrn);
  assign elapsed_inc = 7'(elapsed_q + 7'd1);
  assign headroom    = 7'(GreenMax - elapsed_inc);
  assign ext_rem     = (headroom < ExtStep) ? headroom : ExtStep;
  // Extension only for a lone waiting road; the decision counts the tick that ends the green.
  assign want_ext    = ((state_q == StAGrn) && a_tr && !b_tr) ||
                       ((state_q == StBGrn) && b_tr && !a_tr);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    elapsed_d = elapsed_q;
    lit_d     = lit_q;
    do_count  = 1'b0;

    if (ovr_req) begin
      if (state_q == target) begin
        // Held: countdown frozen.
      end else if (state_q == other) begin
        state_d   = (other == StAGrn) ? StAYel : StBYel;
        rem_d     = YellowT;
        elapsed_d = '0;
      end else if (state_q == StFlash) begin
        state_d   = ovr_road ? StAr1 : StAr2;
        rem_d     = AllredT;
        elapsed_d = '0;
      end else begin
        do_count = 1'b1;
      end
    end else if (flash_en) begin
      if (state_q != StFlash) begin
        state_d   = StFlash;
        lit_d     = 1'b1;
        rem_d     = '0;
        elapsed_d = '0;
      end else if (tick) begin
        lit_d = ~lit_q;
      end
    end else if (state_q == StFlash) begin
      state_d = StAr2;
      rem_d   = AllredT;
    end else if (ack_q) begin
      // Override released: the held green starts over from its minimum.
      rem_d     = GreenMin;
      elapsed_d = '0;
    end else begin
      do_count = 1'b1;
    end

    if (do_count && tick) begin
      if (rem_q > 7'd1) begin
        rem_d = 7'(rem_q - 7'd1);
        if (is_green) elapsed_d = elapsed_inc;
      end else if (want_ext && (elapsed_inc < GreenMax)) begin
        rem_d     = ext_rem;
        elapsed_d = elapsed_inc;
      end else begin
        state_d   = seq_next;
        rem_d     = load_of(seq_next);
        elapsed_d = '0;
      end
    end
  end

  assign ack_d = ovr_req && (state_d == target);

  always_comb begin
    a_light_d = LampRed;
    b_light_d = LampRed;
    case (state_d)
      StAGrn:  a_light_d = LampGrn;
      StAYel:  a_light_d = LampYel;
      StBGrn:  b_light_d = LampGrn;
      StBYel:  b_light_d = LampYel;
      StFlash: begin
        a_light_d = lit_d ? LampYel : LampOff;
        b_light_d = lit_d ? LampYel : LampOff;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StAr2;
      rem_q     <= AllredT;
      elapsed_q <= '0;
      ack_q     <= 1'b0;
      lit_q     <= 1'b1;
      a_light_q <= LampRed;
      b_light_q <= LampRed;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      elapsed_q <= elapsed_d;
      ack_q     <= ack_d;
      lit_q     <= lit_d;
      a_light_q <= a_light_d;
      b_light_q <= b_light_d;
    end
  end

  logic blank;
  assign blank   = ack_q || (state_q == StFlash);
  assign ovr_ack = ack_q;
  assign a_light = a_light_q;
  assign b_light = b_light_q;
  assign phase   = state_q;
  assign ti_h    = blank ? 4'd0 : 4'(rem_q / 7'd10);
  assign ti_l    = blank ? 4'd0 : 4'(rem_q % 7'd10);

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
module tb_intersection_phase_scheduler;

  localparam int GMIN = 10;
  localparam int GMAX = 30;
  localparam int EXT  = 5;
  localparam int YEL  = 3;
  localparam int AR   = 1;

  logic       clk = 1'b0;
  logic       rst, tick, a_tr, b_tr, ovr_req, ovr_road, flash_en;
  logic       ovr_ack;
  logic [1:0] a_light, b_light;
  logic [3:0] ti_l, ti_h;
  logic [2:0] phase;

  intersection_phase_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .a_tr     (a_tr),
    .b_tr     (b_tr),
    .ovr_req  (ovr_req),
    .ovr_road (ovr_road),
    .ovr_ack  (ovr_ack),
    .flash_en (flash_en),
    .a_light  (a_light),
    .b_light  (b_light),
    .ti_l     (ti_l),
    .ti_h     (ti_h),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [1:0] al;
    logic [1:0] bl;
    logic       ack;
    logic [3:0] th;
    logic [3:0] tl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tcnt   = 0;

  // Reference model: phase numbers as in the phase code, durations in plain integers.
  int m_phase, m_rem, m_el;
  bit m_ack, m_lit;
  int seq_next[6] = '{1, 2, 3, 4, 5, 0};

  function automatic int load_for(int p);
    if (p == 0 || p == 3) return GMIN;
    if (p == 1 || p == 4) return YEL;
    return AR;
  endfunction

  task automatic count_down(input bit tk, input bit a, input bit b);
    bit green, lone;
    if (!tk) return;
    green = (m_phase == 0 || m_phase == 3);
    lone  = (m_phase == 0) ? (a && !b) : (b && !a);
    if (green) m_el++;
    if (m_rem > 1) m_rem--;
    else if (green && lone && m_el < GMAX) m_rem = (GMAX - m_el < EXT) ? GMAX - m_el : EXT;
    else begin
      m_phase = seq_next[m_phase];
      m_rem   = load_for(m_phase);
      m_el    = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit tk, input bit a, input bit b,
                            input bit ovr, input bit road, input bit fl);
    int tgt, oth;
    bit prev_ack;
    if (!r) begin
      m_phase = 5; m_rem = AR; m_el = 0; m_ack = 0; m_lit = 1;
      return;
    end
    prev_ack = m_ack;
    tgt = road ? 3 : 0;
    oth = road ? 0 : 3;
    if (ovr) begin
      if (m_phase == tgt) begin
      end else if (m_phase == oth) begin
        m_phase = oth + 1; m_rem = YEL; m_el = 0;
      end else if (m_phase == 6) begin
        m_phase = road ? 2 : 5; m_rem = AR; m_el = 0;
      end else count_down(tk, a, b);
      m_ack = (m_phase == tgt);
    end else begin
      m_ack = 0;
      if (fl) begin
        if (m_phase != 6) begin
          m_phase = 6; m_lit = 1; m_el = 0; m_rem = 0;
        end else if (tk) m_lit = !m_lit;
      end else if (m_phase == 6) begin
        m_phase = 5; m_rem = AR;
      end else if (prev_ack) begin
        m_rem = GMIN; m_el = 0;
      end else count_down(tk, a, b);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   shown;
    e.ph  = 3'(m_phase);
    e.ack = m_ack;
    if (m_phase == 6) begin
      e.al = m_lit ? 2'b01 : 2'b11;
      e.bl = e.al;
    end else begin
      e.al = (m_phase == 0) ? 2'b10 : (m_phase == 1) ? 2'b01 : 2'b00;
      e.bl = (m_phase == 3) ? 2'b10 : (m_phase == 4) ? 2'b01 : 2'b00;
    end
    shown = (m_ack || m_phase == 6) ? 0 : m_rem;
    e.th  = 4'(shown / 10);
    e.tl  = 4'(shown % 10);
    return e;
  endfunction

  // One clock of stimulus; the expected outputs after the next edge go to the scoreboard.
  task automatic step(input bit r, input bit tk, input bit a, input bit b,
                      input bit ovr, input bit road, input bit fl);
    @(negedge clk);
    rst = r; tick = tk; a_tr = a; b_tr = b; ovr_req = ovr; ovr_road = road; flash_en = fl;
    model_step(r, tk, a, b, ovr, road, fl);
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n, input bit a, input bit b, input bit ovr, input bit road,
                     input bit fl);
    for (int i = 0; i < n; i++) begin
      step(1'b1, (tcnt % 4) == 0, a, b, ovr, road, fl);
      tcnt++;
    end
  endtask

  // Monitor: every cycle is one output transaction.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = '{ph: phase, al: a_light, bl: b_light, ack: ovr_ack, th: ti_h, tl: ti_l};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got ph=%0d a=%b b=%b ack=%b ti=%0d%0d, required ph=%0d a=%b b=%b ack=%b ti=%0d%0d",
                   $time, got.ph, got.al, got.bl, got.ack, got.th, got.tl,
                   e.ph, e.al, e.bl, e.ack, e.th, e.tl);
        end
        checks++;
        if (phase !== 3'd6 && a_light !== 2'b00 && b_light !== 2'b00) begin
          errors++;
          $display("FAIL safety t=%0t: got a=%b b=%b in phase %0d, required at least one red",
                   $time, a_light, b_light, phase);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a, b, ovr, road, fl;
    int n;
    rst = 0; tick = 0; a_tr = 0; b_tr = 0; ovr_req = 0; ovr_road = 0; flash_en = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 0, 0, 0);

    run(250, 0, 0, 0, 0, 0);   // plain cycle
    run(700, 1, 0, 0, 0, 0);   // A demand only: full extensions
    run(300, 1, 1, 0, 0, 0);   // both demand: no extension
    run(40, 0, 0, 0, 0, 0);
    run(400, 0, 0, 1, 1, 0);   // override to B, held
    run(100, 0, 0, 0, 1, 0);   // release
    run(150, 0, 0, 1, 0, 0);   // override to A
    run(60, 0, 0, 1, 1, 0);    // retarget while acked
    run(30, 0, 0, 0, 0, 0);
    run(300, 0, 0, 0, 0, 1);   // flash
    run(60, 0, 0, 0, 0, 0);
    run(200, 0, 0, 1, 0, 1);   // override beats flash
    run(50, 0, 0, 0, 0, 1);    // drop override, flash stays
    run(50, 0, 0, 1, 1, 1);    // override to B out of flash
    run(30, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1, 0, 0, 0, 0);  // reset with coincident tick
    run(100, 0, 1, 0, 0, 0);

    for (int s = 0; s < 40; s++) begin
      n    = $urandom_range(10, 300);
      a    = 1'($urandom_range(0, 1));
      b    = 1'($urandom_range(0, 1));
      ovr  = ($urandom_range(0, 3) == 0);
      road = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) step(1'b0, 1'($urandom_range(0, 1)), a, b, ovr, road, fl);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 40) == 0) a = !a;
        if ($urandom_range(0, 40) == 0) b = !b;
        step(1'b1, ($urandom_range(0, 3) == 0), a, b, ovr, road, fl);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
